// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with frame-based debounce
//
// Ports:
//   clk      : system clock, all state changes on its rising edge
//   rst      : asynchronous active-low reset
//   row      : keypad row lines, active-low, asynchronous to clk
//   col      : column drive, exactly one bit low at a time
//   code     : accepted key code, 4*row_index + col_index, held after release
//   keydown  : high while a debounced key is held (registered)
//   scan_clk : divider MSB, period 2^DIV_W clk cycles
module keypad_scanner #(
    parameter int DIV_W      = 16,
    parameter int DEB_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] code,
    output logic       keydown,
    output logic       scan_clk
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        DOWN,
        REL_CHK
    } state_t;

    localparam logic [3:0]       DEB     = 4'(DEB_FRAMES);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div;
    logic [1:0]       c;
    logic             tick;
    logic             frame_end;

    // Running minimum over the samples already taken in the current frame.
    logic             best_vld;
    logic [3:0]       best;

    logic             samp_vld;
    logic [3:0]       samp_code;
    logic             acc_vld;
    logic             res_vld;
    logic [3:0]       res_code;

    state_t           state;
    logic [3:0]       n;
    logic [3:0]       k;

    assign tick      = &div;
    assign frame_end = tick && (c == 2'd3);
    assign scan_clk  = div[DIV_W-1];
    assign col       = ~(4'b0001 << c);

    // Lowest pressed row in the column currently driven; scanning from the
    // top row down leaves the lowest index as the final assignment.
    always_comb begin
        samp_vld  = 1'b0;
        samp_code = 4'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync[r]) begin
                samp_vld  = 1'b1;
                samp_code = {r[1:0], c};
            end
        end
    end

    // Column 0 opens a new frame, so the accumulator is ignored there.
    always_comb begin
        acc_vld  = best_vld && (c != 2'd0);
        res_vld  = acc_vld;
        res_code = best;
        if (samp_vld && (!acc_vld || samp_code < best)) begin
            res_vld  = 1'b1;
            res_code = samp_code;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
            div      <= '0;
            c        <= 2'd0;
            best_vld <= 1'b0;
            best     <= 4'd0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            div      <= div + DIV_ONE;
            if (tick) begin
                c        <= c + 2'd1;
                best_vld <= res_vld;
                best     <= res_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            n       <= 4'd0;
            k       <= 4'd0;
            code    <= 4'd0;
            keydown <= 1'b0;
        end else if (frame_end) begin
            case (state)
                IDLE: begin
                    if (res_vld) begin
                        k <= res_code;
                        n <= 4'd1;
                        if (DEB == 4'd1) begin
                            state   <= DOWN;
                            code    <= res_code;
                            keydown <= 1'b1;
                        end else begin
                            state <= PRESS_CHK;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (!res_vld) begin
                        state <= IDLE;
                    end else if (res_code == k) begin
                        n <= n + 4'd1;
                        if (n + 4'd1 == DEB) begin
                            state   <= DOWN;
                            code    <= k;
                            keydown <= 1'b1;
                        end
                    end else begin
                        k <= res_code;
                        n <= 4'd1;
                    end
                end
                DOWN: begin
                    // Other keys are ignored until a debounced release.
                    if (!res_vld) begin
                        n <= 4'd1;
                        if (DEB == 4'd1) begin
                            state   <= IDLE;
                            keydown <= 1'b0;
                        end else begin
                            state <= REL_CHK;
                        end
                    end
                end
                REL_CHK: begin
                    if (!res_vld) begin
                        n <= n + 4'd1;
                        if (n + 4'd1 == DEB) begin
                            state   <= IDLE;
                            keydown <= 1'b0;
                        end
                    end else begin
                        state <= DOWN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;

    localparam int DIV_W = 2;
    localparam int DEB   = 2;
    localparam int NONE  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  code;
    logic        keydown;
    logic        scan_clk;
    logic [15:0] keys;

    int vectors    = 0;
    int miscompares = 0;
    int cyc;

    int   hist[$];
    bit   m_down;
    logic [3:0] m_code;

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++)
                if (!col[cc] && keys[4*r+cc]) row[r] = 1'b0;
    end

    keypad_scanner #(.DIV_W(DIV_W), .DEB_FRAMES(DEB)) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .code     (code),
        .keydown  (keydown),
        .scan_clk (scan_clk)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [15:0] m);
        for (int i = 0; i < 16; i++)
            if (m[i]) return i;
        return NONE;
    endfunction

    // Accept when the last DEB frame results all name the same key;
    // release when the last DEB frame results are all empty.
    task automatic model_frame(input logic [15:0] m);
        int v;
        bit all;
        hist.push_back(lowest(m));
        if (hist.size() >= DEB) begin
            v   = hist[hist.size()-1];
            all = 1'b1;
            for (int i = 1; i <= DEB; i++)
                if (hist[hist.size()-i] != v) all = 1'b0;
            if (all && !m_down && v != NONE) begin
                m_down = 1'b1;
                m_code = 4'(v);
            end else if (all && m_down && v == NONE) begin
                m_down = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_down = 1'b0;
        m_code = 4'd0;
    endtask

    task automatic run_frame(input logic [15:0] m);
        logic [3:0] exp_col;
        keys = m;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            exp_col = ~(4'b0001 << ((cyc / 4) % 4));
            check("col", {4'h0, col}, {4'h0, exp_col});
            check("scan_clk", {7'h0, scan_clk}, {7'h0, ((cyc % 4) >= 2)});
            if (i == 15) model_frame(m);
            check("keydown", {7'h0, keydown}, {7'h0, m_down});
            check("code", {4'h0, code}, {4'h0, m_code});
        end
    endtask

    task automatic finish_reset();
        repeat (2) @(negedge clk);
        check("rst_col", {4'h0, col}, 8'h0E);
        check("rst_code", {4'h0, code}, 8'h00);
        check("rst_keydown", {7'h0, keydown}, 8'h00);
        check("rst_scan_clk", {7'h0, scan_clk}, 8'h00);
        rst = 1'b1;
        cyc = 0;
        model_reset();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        finish_reset();
    endtask

    task automatic async_reset_pulse();
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("async_keydown", {7'h0, keydown}, 8'h00);
        finish_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] m;
        int sel;
        int len;
        rst  = 1'b0;
        keys = 16'h0;
        cyc  = 0;
        model_reset();
        apply_reset();

        repeat (3) run_frame(16'h0000);

        repeat (3) run_frame(16'h0002);
        repeat (3) run_frame(16'h0000);

        repeat (3) begin
            run_frame(16'h0040);
            run_frame(16'h0000);
        end

        repeat (3) run_frame(16'h000C);
        repeat (3) run_frame(16'h0008);
        repeat (3) run_frame(16'h0000);

        repeat (3) run_frame(16'h0020);
        run_frame(16'h0000);
        repeat (2) run_frame(16'h0020);
        repeat (3) run_frame(16'h0000);

        repeat (3) run_frame(16'h0200);
        check("pre_rst_keydown", {7'h0, keydown}, 8'h01);
        async_reset_pulse();
        repeat (3) run_frame(16'h0200);
        repeat (3) run_frame(16'h0000);

        m = 16'h0;
        repeat (50) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: m = 16'h0;
                1: m = m;
                2: m = 16'h1 << $urandom_range(0, 15);
                default: m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            endcase
            len = $urandom_range(1, 3);
            repeat (len) run_frame(m);
        end
        repeat (3) run_frame(16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
